// File: rtl/data_mem_delayed.sv
// Multi-cycle word-addressed data memory for the MEM stage.
// Holds each load/store for LATENCY stall cycles, then commits or returns data on one DONE cycle.
module data_mem_delayed #(
    parameter int unsigned AW      = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MemDoneM
);

    localparam int unsigned DEPTH = 32'(1) << AW;
    localparam int unsigned CW    = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   w_wdata;
    logic          r_is_wr;
    logic          w_is_wr;
    logic          w_req;
    logic          w_latch;
    logic          w_enter_done;
    logic          w_unused;

    logic [31:0]   r_mem [DEPTH];

    assign w_req    = MemReadM | MemWriteM;
    assign w_unused = &{1'b0, ALUOutM[31:AW+2], ALUOutM[1:0]};

    // On the accepting edge the live inputs are used, afterwards the latched copy.
    assign w_addr  = w_latch ? ALUOutM[AW+1:2] : r_addr;
    assign w_wdata = w_latch ? WriteDataM      : r_wdata;
    assign w_is_wr = w_latch ? MemWriteM       : r_is_wr;

    // Next-state and counter logic
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_latch    = 1'b1;
                    w_next_cnt = CW'(1);
                    if (LATENCY == 1) begin
                        w_next_state = S_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next_state = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!w_req) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                    if (r_cnt == CW'(LATENCY - 1)) begin
                        w_next_state = S_DONE;
                        w_enter_done = 1'b1;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_wr   <= 1'b0;
            ReadDataM <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_latch) begin
                r_addr  <= ALUOutM[AW+1:2];
                r_wdata <= WriteDataM;
                r_is_wr <= MemWriteM;
            end
            if (w_enter_done && !w_is_wr) begin
                ReadDataM <= r_mem[w_addr];
            end
        end
    end

    // RAM is never reset; a store is only committed while out of reset.
    always_ff @(posedge clk) begin
        if (reset_n && w_enter_done && w_is_wr) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    assign MemStallM = reset_n & w_req & (r_state != S_DONE);
    assign MemDoneM  = reset_n & (r_state == S_DONE);

endmodule
